// File: rtl/brick_map_writer.sv
// Owns the 30x40 brick map: loads a level from a row ROM and clears bricks struck by the bullet.
// Define STEEL_BLOCKS_EN to add indestructible steel cells loaded alongside the bricks.
module brick_map_writer (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        level_load,
    output logic [4:0]  level_row_addr,
    input  logic [39:0] level_row_data,
    input  logic        bullet_active,
    input  logic [9:0]  bullet_x,
    input  logic [9:0]  bullet_y,
    input  logic [3:0]  bullet_dir,
    output logic [39:0] brick_map [0:29],
    output logic        bullet_hit,
    output logic [4:0]  hit_row,
    output logic [5:0]  hit_col,
    output logic [10:0] bricks_remaining,
`ifdef STEEL_BLOCKS_EN
    input  logic [39:0] level_row_steel,
    output logic [39:0] steel_map [0:29],
`endif
    output logic        busy
);

    localparam int unsigned BulletSz = 8;
    localparam int unsigned Half     = BulletSz / 2;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  row_cnt_q, row_cnt_d;
    logic [10:0] count_q, count_d;
    logic        lock_q, lock_d;
    logic        bullet_hit_q;
    logic [4:0]  hit_row_q;
    logic [5:0]  hit_col_q;
    logic [39:0] brick_q [0:29];

    logic [10:0] px, py;
    logic [10:0] cell_row, cell_col;
    logic        dir_ok, in_map, probe_en;
    logic [4:0]  row_idx;
    logic [5:0]  bit_idx;
    logic        brick_hit, steel_hit;

    function automatic logic [10:0] popcount(input logic [39:0] v);
        logic [10:0] n;
        n = '0;
        for (int i = 0; i < 40; i++) n = n + 11'(v[i]);
        return n;
    endfunction

    // Probe the centre of the bullet's leading edge; 11-bit sums so the far edge cannot wrap.
    always_comb begin
        px = {1'b0, bullet_x};
        py = {1'b0, bullet_y};
        case (bullet_dir)
            4'b0001: px = {1'b0, bullet_x} + 11'(Half);
            4'b0010: begin
                px = {1'b0, bullet_x} + 11'(Half);
                py = {1'b0, bullet_y} + 11'(BulletSz - 1);
            end
            4'b0100: py = {1'b0, bullet_y} + 11'(Half);
            4'b1000: begin
                px = {1'b0, bullet_x} + 11'(BulletSz - 1);
                py = {1'b0, bullet_y} + 11'(Half);
            end
            default: ;
        endcase
    end

    assign dir_ok   = $onehot(bullet_dir);
    assign cell_row = py >> 4;
    assign cell_col = px >> 4;
    assign in_map   = (cell_row < 11'd30) && (cell_col < 11'd40);
    assign row_idx  = in_map ? cell_row[4:0] : 5'd0;
    assign bit_idx  = in_map ? 6'd39 - cell_col[5:0] : 6'd0;

    // A load request in the same cycle suppresses any strike.
    assign probe_en  = (state_q == RUN) && !level_load && bullet_active && !lock_q &&
                       dir_ok && in_map;
    assign brick_hit = probe_en && brick_q[row_idx][bit_idx];

`ifdef STEEL_BLOCKS_EN
    logic [39:0] steel_q [0:29];
    assign steel_hit = probe_en && !brick_q[row_idx][bit_idx] && steel_q[row_idx][bit_idx];
    assign steel_map = steel_q;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int r = 0; r < 30; r++) steel_q[r] <= '0;
        end else if (state_q == LOAD) begin
            steel_q[row_cnt_q] <= level_row_steel;
        end
    end
`else
    assign steel_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        if (state_q == LOAD) begin
            if (level_load) begin
                row_cnt_d = 5'd0;
            end else if (row_cnt_q == 5'd29) begin
                state_d   = RUN;
                row_cnt_d = 5'd0;
            end else begin
                row_cnt_d = row_cnt_q + 5'd1;
            end
        end else if (level_load) begin
            state_d   = LOAD;
            row_cnt_d = 5'd0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (state_q == LOAD) begin
            count_d = ((row_cnt_q == 5'd0) ? 11'd0 : count_q) + popcount(level_row_data);
        end else if (brick_hit && count_q != 11'd0) begin
            count_d = count_q - 11'd1;
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (brick_hit || steel_hit) begin
            lock_d = 1'b1;
        end else if (!bullet_active) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= LOAD;
            row_cnt_q    <= 5'd0;
            count_q      <= 11'd0;
            lock_q       <= 1'b0;
            bullet_hit_q <= 1'b0;
            hit_row_q    <= 5'd0;
            hit_col_q    <= 6'd0;
            for (int r = 0; r < 30; r++) brick_q[r] <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            bullet_hit_q <= brick_hit | steel_hit;
            if (brick_hit || steel_hit) begin
                hit_row_q <= row_idx;
                hit_col_q <= cell_col[5:0];
            end
            if (state_q == LOAD) begin
                brick_q[row_cnt_q] <= level_row_data;
            end else if (brick_hit) begin
                brick_q[row_idx][bit_idx] <= 1'b0;
            end
        end
    end

    assign level_row_addr   = (state_q == LOAD) ? row_cnt_q : 5'd0;
    assign busy             = (state_q == LOAD);
    assign brick_map        = brick_q;
    assign bullet_hit       = bullet_hit_q;
    assign hit_row          = hit_row_q;
    assign hit_col          = hit_col_q;
    assign bricks_remaining = count_q;

endmodule

// File: tb/tb_brick_map_writer.sv
// Bench for brick_map_writer: directed level/bullet scenarios plus random traffic against a
// cell-level model of the map.
`timescale 1ns/1ps
module tb_brick_map_writer;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        level_load = 1'b0;
    logic [4:0]  level_row_addr;
    logic [39:0] level_row_data;
    logic        bullet_active = 1'b0;
    logic [9:0]  bullet_x = 10'd0;
    logic [9:0]  bullet_y = 10'd0;
    logic [3:0]  bullet_dir = 4'b0001;
    logic [39:0] brick_map [0:29];
    logic        bullet_hit;
    logic [4:0]  hit_row;
    logic [5:0]  hit_col;
    logic [10:0] bricks_remaining;
    logic        busy;

    logic [39:0] rom [0:29];
    assign level_row_data = (level_row_addr < 5'd30) ? rom[level_row_addr] : 40'h0;

`ifdef STEEL_BLOCKS_EN
    logic [39:0] rom_steel [0:29];
    logic [39:0] level_row_steel;
    logic [39:0] steel_map [0:29];
    logic [39:0] m_steel [0:29];
    assign level_row_steel = (level_row_addr < 5'd30) ? rom_steel[level_row_addr] : 40'h0;
`endif

    brick_map_writer dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .level_load      (level_load),
        .level_row_addr  (level_row_addr),
        .level_row_data  (level_row_data),
        .bullet_active   (bullet_active),
        .bullet_x        (bullet_x),
        .bullet_y        (bullet_y),
        .bullet_dir      (bullet_dir),
        .brick_map       (brick_map),
        .bullet_hit      (bullet_hit),
        .hit_row         (hit_row),
        .hit_col         (hit_col),
        .bricks_remaining(bricks_remaining),
`ifdef STEEL_BLOCKS_EN
        .level_row_steel (level_row_steel),
        .steel_map       (steel_map),
`endif
        .busy            (busy)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the map as a plain array of cells, updated once per frame.
    logic [39:0] m_map [0:29];
    bit          m_valid = 1'b0;
    bit          m_loading, m_hit, m_lock;
    int          m_row, m_hr, m_hc;

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++) n += int'(m_map[r][c]);
        return n;
    endfunction

    task automatic m_probe();
        int px, py, r, c;
        px = int'(bullet_x);
        py = int'(bullet_y);
        case (bullet_dir)
            4'b0001: px += 4;
            4'b0010: begin px += 4; py += 7; end
            4'b0100: py += 4;
            4'b1000: begin px += 7; py += 4; end
            default: return;
        endcase
        r = py / 16;
        c = px / 16;
        if (r >= 30 || c >= 40) return;
        if (m_map[r][39-c]) begin
            m_map[r][39-c] = 1'b0;
            m_hit = 1; m_lock = 1; m_hr = r; m_hc = c;
        end
`ifdef STEEL_BLOCKS_EN
        else if (m_steel[r][39-c]) begin
            m_hit = 1; m_lock = 1; m_hr = r; m_hc = c;
        end
`endif
    endtask

    always @(posedge frame_clk) begin
        if (Reset) begin
            for (int r = 0; r < 30; r++) m_map[r] = '0;
`ifdef STEEL_BLOCKS_EN
            for (int r = 0; r < 30; r++) m_steel[r] = '0;
`endif
            m_loading = 1; m_row = 0; m_lock = 0; m_hit = 0; m_hr = 0; m_hc = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_hit = 0;
            if (m_loading) begin
                m_map[m_row] = rom[m_row];
`ifdef STEEL_BLOCKS_EN
                m_steel[m_row] = rom_steel[m_row];
`endif
                if (level_load) m_row = 0;
                else if (m_row == 29) begin m_loading = 0; m_row = 0; end
                else m_row++;
            end else if (level_load) begin
                m_loading = 1; m_row = 0;
            end else if (bullet_active && !m_lock) begin
                m_probe();
            end
            if (!bullet_active) m_lock = 0;
        end
    end

    int cyc = 0;
    always @(negedge frame_clk) begin : compare
        int idx;
        idx = -1;
        if (m_valid) begin
            cyc++;
            chk("busy", 64'(busy), 64'(m_loading));
            chk("row_addr", 64'(level_row_addr), 64'(m_loading ? m_row : 0));
            chk("bullet_hit", 64'(bullet_hit), 64'(m_hit));
            chk("hit_row", 64'(hit_row), 64'(m_hr));
            chk("hit_col", 64'(hit_col), 64'(m_hc));
            for (int r = 0; r < 30; r++)
                if (idx < 0 && brick_map[r] !== m_map[r]) idx = r;
            if (idx < 0) idx = cyc % 30;
            chk($sformatf("map_row%0d", idx), 64'(brick_map[idx]), 64'(m_map[idx]));
`ifdef STEEL_BLOCKS_EN
            chk("steel_row", 64'(steel_map[cyc % 30]), 64'(m_steel[cyc % 30]));
`endif
            if (!m_loading) chk("bricks_remaining", 64'(bricks_remaining), 64'(m_count()));
        end
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge frame_clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic reload();
        tick();
        level_load = 1'b1;
        tick();
        level_load = 1'b0;
    endtask

    task automatic clear_rom();
        for (int r = 0; r < 30; r++) rom[r] = '0;
`ifdef STEEL_BLOCKS_EN
        for (int r = 0; r < 30; r++) rom_steel[r] = '0;
`endif
    endtask

    initial begin
        int n;
        logic [63:0] a;
        clear_rom();
        for (int r = 0; r < 30; r++) rom[r] = 40'h00000_000FF;

        // Reset values, then the automatic first load
        tick();
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_count", 64'(bricks_remaining), 64'(0));
        chk("rst_hit", 64'(bullet_hit), 64'(0));
        chk("rst_map0", 64'(brick_map[0]), 64'(0));
        tick();
        Reset = 1'b0;
        count_busy(n);
        chk("t1_busy_cycles", 64'(n), 64'(30));
        chk("t1_count", 64'(bricks_remaining), 64'(240));
        chk("t1_row0", 64'(brick_map[0]), 64'h00000_000FF);
        chk("t1_row29", 64'(brick_map[29]), 64'h00000_000FF);

        // Single brick struck from below
        clear_rom();
        rom[9]  = 40'h1 << 19;
        rom[10] = 40'h1 << 19;
        reload();
        count_busy(n);
        chk("t2_busy_cycles", 64'(n), 64'(30));
        tick();
        bullet_x = 10'd316; bullet_y = 10'd160; bullet_dir = 4'b0001; bullet_active = 1'b1;
        tick();
        @(negedge frame_clk);
        chk("t2_hit", 64'(bullet_hit), 64'(1));
        chk("t2_hit_row", 64'(hit_row), 64'(10));
        chk("t2_hit_col", 64'(hit_col), 64'(20));
        chk("t2_row10", 64'(brick_map[10]), 64'(0));
        chk("t2_count", 64'(bricks_remaining), 64'(1));
        tick();
        @(negedge frame_clk);
        chk("t2_pulse_end", 64'(bullet_hit), 64'(0));

        // Held bullet is locked out until it drops for one cycle
        tick();
        bullet_y = 10'd150;
        repeat (5) tick();
        @(negedge frame_clk);
        chk("t3_locked_row9", 64'(brick_map[9]), 64'(40'h1 << 19));
        chk("t3_locked_count", 64'(bricks_remaining), 64'(1));
        bullet_active = 1'b0;
        tick();
        bullet_active = 1'b1;
        tick();
        @(negedge frame_clk);
        chk("t3_rehit", 64'(bullet_hit), 64'(1));
        chk("t3_rehit_row", 64'(hit_row), 64'(9));
        chk("t3_count", 64'(bricks_remaining), 64'(0));

        // Probe beyond the right edge and a non-one-hot direction
        tick();
        bullet_active = 1'b0;
        clear_rom();
        rom[6] = 40'hFF_FFFF_FFFF;
        reload();
        count_busy(n);
        tick();
        bullet_x = 10'd636; bullet_y = 10'd100; bullet_dir = 4'b1000; bullet_active = 1'b1;
        repeat (3) tick();
        @(negedge frame_clk);
        chk("t4_edge_hit", 64'(bullet_hit), 64'(0));
        chk("t4_edge_row6", 64'(brick_map[6]), 64'hFF_FFFF_FFFF);
        tick();
        bullet_x = 10'd100; bullet_y = 10'd96; bullet_dir = 4'b0011;
        repeat (3) tick();
        @(negedge frame_clk);
        chk("t4_baddir_row6", 64'(brick_map[6]), 64'hFF_FFFF_FFFF);
        chk("t4_count", 64'(bricks_remaining), 64'(40));

        // Load request collides with a hit condition: the load wins
        tick();
        bullet_x = 10'd0; bullet_y = 10'd96; bullet_dir = 4'b0001; level_load = 1'b1;
        tick();
        level_load = 1'b0;
        count_busy(n);
        chk("t5_busy_cycles", 64'(n), 64'(30));
        chk("t5_row6", 64'(brick_map[6]), 64'hFF_FFFF_FFFF);
        chk("t5_count", 64'(bricks_remaining), 64'(40));
        tick();
        bullet_active = 1'b0;

`ifdef STEEL_BLOCKS_EN
        // Steel cell stops the bullet but survives
        clear_rom();
        rom[0] = 40'h1;
        rom_steel[5] = 40'h1 << (39 - 7);
        reload();
        count_busy(n);
        tick();
        bullet_x = 10'd112; bullet_y = 10'd80; bullet_dir = 4'b0100; bullet_active = 1'b1;
        tick();
        @(negedge frame_clk);
        chk("t6_steel_hit", 64'(bullet_hit), 64'(1));
        chk("t6_steel_kept", 64'(steel_map[5]), 64'(40'h1 << (39 - 7)));
        chk("t6_count", 64'(bricks_remaining), 64'(1));
        tick();
        bullet_active = 1'b0;
`endif

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            tick();
            Reset = ($urandom_range(0, 499) == 0);
            level_load = ($urandom_range(0, 79) == 0);
            if (level_load || $urandom_range(0, 49) == 0) begin
                for (int r = 0; r < 30; r++) begin
                    a = {$urandom(), $urandom()} & {$urandom(), $urandom()};
                    rom[r] = a[39:0];
`ifdef STEEL_BLOCKS_EN
                    a = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
                    rom_steel[r] = a[39:0];
`endif
                end
            end
            bullet_active = ($urandom_range(0, 4) != 0);
            bullet_x = 10'($urandom_range(0, 680));
            bullet_y = 10'($urandom_range(0, 520));
            if ($urandom_range(0, 9) == 0) bullet_dir = 4'($urandom_range(0, 15));
            else bullet_dir = 4'b0001 << $urandom_range(0, 3);
        end
        tick();
        Reset = 1'b0;
        level_load = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
